// File: rtl/mod_updown_counter_pkg.sv
// Shared constants, step encoding and a ceil-log2 helper for the modulo-N up/down counter.
package mod_updown_counter_pkg;

  localparam logic CNT_DIR_UP   = 1'b1;
  localparam logic CNT_DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_LOAD,
    STEP_UP,
    STEP_DOWN
  } step_e;

  // Bits needed to hold values 0..value-1; used for parameter checks.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of the modulo-N counter.
// The ovf_clr/ovf_sticky pair exists only when MODCNT_STICKY_EN is defined.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
`ifdef MODCNT_STICKY_EN
  logic             ovf_clr;
  logic             ovf_sticky;
`endif

`ifdef MODCNT_STICKY_EN
  modport master (
    output en, up, load, load_val, ovf_clr,
    input  count, tc, wrap, ovf_sticky
  );

  modport slave (
    input  en, up, load, load_val, ovf_clr,
    output count, tc, wrap, ovf_sticky
  );
`else
  modport master (
    output en, up, load, load_val,
    input  count, tc, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output count, tc, wrap
  );
`endif

endinterface

// File: rtl/mod_counter_next.sv
// Combinational next-state logic of the modulo-N counter: picks load/step/hold
// and flags the step that wraps around the count range.
module mod_counter_next
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_step
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  step_e step;
  logic  at_max;
  logic  at_zero;
  logic  out_of_range;
  logic  load_oor;

  // One extra bit so MODULUS == 2**WIDTH compares correctly.
  assign at_max       = (count == MAX_VAL);
  assign at_zero      = (count == '0);
  assign out_of_range = ({1'b0, count} >= MOD_EXT);
  assign load_oor     = ({1'b0, load_val} >= MOD_EXT);

  always_comb begin
    step = STEP_HOLD;
    if (load) begin
      step = STEP_LOAD;
    end else if (en) begin
      step = (up == CNT_DIR_UP) ? STEP_UP : STEP_DOWN;
    end
  end

  // An out-of-range count snaps to the wrap target so no illegal value is produced.
  always_comb begin
    next_count = count;
    wrap_step  = 1'b0;
    unique case (step)
      STEP_LOAD: next_count = load_oor ? MAX_VAL : load_val;
      STEP_UP: begin
        wrap_step  = at_max;
        next_count = (at_max || out_of_range) ? '0 : count + ONE;
      end
      STEP_DOWN: begin
        wrap_step  = at_zero;
        next_count = (at_zero || out_of_range) ? MAX_VAL : count - ONE;
      end
      default: begin
        next_count = count;
      end
    endcase
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised modulo-N up/down counter with load, terminal count and registered wrap pulse.
// Define MODCNT_STICKY_EN to add the ovf_sticky flag with its ovf_clr input.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic                clk,
  input  logic                rst,
  mod_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);

  if (WIDTH < 1 || MODULUS < 2 || clog2(MODULUS) > WIDTH ||
      RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_param_err
    $error("mod_updown_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] next_count;
  logic             wrap_q;
  logic             wrap_d;
  logic             wrap_step;

  mod_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count      (count_q),
    .up         (bus.up),
    .en         (bus.en),
    .load       (bus.load),
    .load_val   (bus.load_val),
    .next_count (next_count),
    .wrap_step  (wrap_step)
  );

  always_comb begin
    count_d = next_count;
    wrap_d  = wrap_step;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RESET_COUNT;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.tc    = (bus.up == CNT_DIR_UP) ? (count_q == MAX_VAL) : (count_q == '0);

`ifdef MODCNT_STICKY_EN
  logic ovf_sticky_q;
  logic ovf_sticky_d;

  // A wrap at the same edge as a clear keeps the flag set.
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (wrap_step) begin
      ovf_sticky_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign bus.ovf_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: MODULUS=10 instance plus a default-parameter (MODULUS=16) instance.
// Sticky-flag sequences are compiled in when MODCNT_STICKY_EN is defined.
module tb_mod_updown_counter;

  localparam int M10 = 10;

  logic clk = 1'b0;
  logic rst;
  logic rst16;

  always #5 clk = ~clk;

  mod_updown_counter_if #(.WIDTH(4)) bus ();
  mod_updown_counter_if #(.WIDTH(4)) bus16 ();

  mod_updown_counter #(
    .WIDTH     (4),
    .MODULUS   (M10),
    .RESET_VAL (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mod_updown_counter dut16 (
    .clk (clk),
    .rst (rst16),
    .bus (bus16)
  );

  typedef struct {
    bit en;
    bit up;
    bit load;
    int load_val;
    int exp_count;
    bit exp_tc;
    bit exp_wrap;
  } vec_t;

  vec_t vectors[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the M10 counter in plain integer arithmetic.
  int m_count = 0;
  bit m_wrap  = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input bit en, input bit up, input bit load, input int load_val);
    int nxt;
    if (load) begin
      m_count = (load_val >= M10) ? M10 - 1 : load_val;
      m_wrap  = 1'b0;
    end else if (en) begin
      nxt     = up ? m_count + 1 : m_count - 1;
      m_wrap  = (nxt >= M10) || (nxt < 0);
      m_count = (nxt + M10) % M10;
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  function automatic bit modelTc(input bit up);
    return up ? (m_count == M10 - 1) : (m_count == 0);
  endfunction

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic applyStimulus(input bit en, input bit up, input bit load, input int load_val);
    bus.en       = en;
    bus.up       = up;
    bus.load     = load;
    bus.load_val = 4'(load_val);
    modelStep(en, up, load, load_val);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step16(input bit en, input bit up, input bit load, input int load_val);
    bus16.en       = en;
    bus16.up       = up;
    bus16.load     = load;
    bus16.load_val = 4'(load_val);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input bit en, input bit up, input bit load, input int lv,
                              input int cnt, input bit tc, input bit wrap);
    vec_t v;
    v.en = en; v.up = up; v.load = load; v.load_val = lv;
    v.exp_count = cnt; v.exp_tc = tc; v.exp_wrap = wrap;
    return v;
  endfunction

  initial begin
    rst   = 1'b0;
    rst16 = 1'b0;
    bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0;
    bus16.en = 1'b0; bus16.up = 1'b1; bus16.load = 1'b0; bus16.load_val = '0;
`ifdef MODCNT_STICKY_EN
    bus.ovf_clr   = 1'b0;
    bus16.ovf_clr = 1'b0;
`endif

    // Up wrap from 0
    for (int k = 1; k <= 12; k++) begin
      vectors.push_back(mk(1, 1, 0, 0, k % 10, (k == 9), (k == 10)));
    end
    // Down wrap from 2
    vectors.push_back(mk(1, 0, 0, 0, 1, 0, 0));
    vectors.push_back(mk(1, 0, 0, 0, 0, 1, 0));
    vectors.push_back(mk(1, 0, 0, 0, 9, 0, 1));
    vectors.push_back(mk(1, 0, 0, 0, 8, 0, 0));
    vectors.push_back(mk(1, 0, 0, 0, 7, 0, 0));
    // Load priority and clamping
    vectors.push_back(mk(1, 1, 1, 5,  5, 0, 0));
    vectors.push_back(mk(1, 1, 1, 12, 9, 1, 0));
    vectors.push_back(mk(1, 1, 1, 9,  9, 1, 0));
    vectors.push_back(mk(1, 1, 1, 15, 9, 1, 0));
    vectors.push_back(mk(0, 0, 1, 0,  0, 1, 0));
    // Hold and direction toggling
    vectors.push_back(mk(0, 1, 1, 4, 4, 0, 0));
    vectors.push_back(mk(0, 1, 0, 0, 4, 0, 0));
    vectors.push_back(mk(0, 1, 0, 0, 4, 0, 0));
    vectors.push_back(mk(0, 1, 0, 0, 4, 0, 0));
    vectors.push_back(mk(1, 1, 0, 0, 5, 0, 0));
    vectors.push_back(mk(1, 0, 0, 0, 4, 0, 0));
    vectors.push_back(mk(1, 1, 0, 0, 5, 0, 0));
    vectors.push_back(mk(1, 0, 0, 0, 4, 0, 0));
    // Hold at the terminal value, then wrap
    vectors.push_back(mk(0, 1, 1, 9, 9, 1, 0));
    vectors.push_back(mk(0, 1, 0, 0, 9, 1, 0));
    vectors.push_back(mk(0, 0, 0, 0, 9, 0, 0));
    vectors.push_back(mk(1, 1, 0, 0, 0, 0, 1));

    // Reset is visible before the first clock edge
    #2;
    checkOutput("reset_count",   32'(bus.count),   32'd0);
    checkOutput("reset_wrap",    32'(bus.wrap),    32'd0);
    checkOutput("reset_tc",      32'(bus.tc),      32'd0);
    checkOutput("reset16_count", 32'(bus16.count), 32'd0);
`ifdef MODCNT_STICKY_EN
    checkOutput("reset_sticky",  32'(bus.ovf_sticky), 32'd0);
`endif
    @(negedge clk);
    rst   = 1'b1;
    rst16 = 1'b1;

    // Asynchronous reset in the middle of counting
    for (int k = 0; k < 7; k++) applyStimulus(1, 1, 0, 0);
    checkOutput("pre_reset_count", 32'(bus.count), 32'd7);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_count", 32'(bus.count), 32'd0);
    checkOutput("async_reset_wrap",  32'(bus.wrap),  32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("reset_held_count", 32'(bus.count), 32'd0);
    rst     = 1'b1;
    m_count = 0;
    m_wrap  = 1'b0;

    // Directed vector table
    for (int i = 0; i < vectors.size(); i++) begin
      applyStimulus(vectors[i].en, vectors[i].up, vectors[i].load, vectors[i].load_val);
      checkOutput($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vectors[i].exp_count));
      checkOutput($sformatf("vec%0d_tc", i),    32'(bus.tc),    32'(vectors[i].exp_tc));
      checkOutput($sformatf("vec%0d_wrap", i),  32'(bus.wrap),  32'(vectors[i].exp_wrap));
    end

    // Randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      bit r_en;
      bit r_up;
      bit r_load;
      int r_val;
      r_en   = ($urandom_range(0, 9) < 7);
      r_up   = 1'($urandom_range(0, 1));
      r_load = ($urandom_range(0, 15) == 0);
      r_val  = int'($urandom_range(0, 15));
      applyStimulus(r_en, r_up, r_load, r_val);
      checkOutput("rand_count", 32'(bus.count), 32'(m_count));
      checkOutput("rand_wrap",  32'(bus.wrap),  32'(m_wrap));
      checkOutput("rand_tc",    32'(bus.tc),    32'(modelTc(r_up)));
    end

`ifdef MODCNT_STICKY_EN
    // Sticky overflow flag
    bus.ovf_clr = 1'b1;
    applyStimulus(0, 1, 0, 0);
    bus.ovf_clr = 1'b0;
    checkOutput("sticky_clear0", 32'(bus.ovf_sticky), 32'd0);
    applyStimulus(0, 1, 1, 8);
    applyStimulus(1, 1, 0, 0);
    checkOutput("sticky_no_wrap", 32'(bus.ovf_sticky), 32'd0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("sticky_set", 32'(bus.ovf_sticky), 32'd1);
    for (int k = 0; k < 20; k++) applyStimulus(0, 1, 0, 0);
    checkOutput("sticky_persist", 32'(bus.ovf_sticky), 32'd1);
    bus.ovf_clr = 1'b1;
    applyStimulus(0, 1, 0, 0);
    bus.ovf_clr = 1'b0;
    checkOutput("sticky_clear", 32'(bus.ovf_sticky), 32'd0);
    applyStimulus(0, 1, 1, 9);
    bus.ovf_clr = 1'b1;
    applyStimulus(1, 1, 0, 0);
    bus.ovf_clr = 1'b0;
    checkOutput("sticky_set_wins",  32'(bus.ovf_sticky), 32'd1);
    checkOutput("sticky_wrap_count", 32'(bus.count), 32'(m_count));
`endif

    // Default-parameter instance: natural overflow at 15->0 and 0->15
    step16(0, 1, 1, 14);
    checkOutput("m16_load", 32'(bus16.count), 32'd14);
    step16(1, 1, 0, 0);
    checkOutput("m16_count15", 32'(bus16.count), 32'd15);
    checkOutput("m16_tc15",    32'(bus16.tc),    32'd1);
    step16(1, 1, 0, 0);
    checkOutput("m16_up_wrap_count", 32'(bus16.count), 32'd0);
    checkOutput("m16_up_wrap",       32'(bus16.wrap),  32'd1);
    step16(1, 0, 0, 0);
    checkOutput("m16_down_wrap_count", 32'(bus16.count), 32'd15);
    checkOutput("m16_down_wrap",       32'(bus16.wrap),  32'd1);
    step16(0, 0, 0, 0);
    checkOutput("m16_hold_wrap", 32'(bus16.wrap),  32'd0);
    checkOutput("m16_hold",      32'(bus16.count), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
